// File: rtl/gpio_irq_if.sv
// gpio_irq_if: channel pins, edge enables and interrupt handshake of gpio_irq_ctrl
interface gpio_irq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_i;
    logic [WIDTH-1:0] rise_en_i;
    logic [WIDTH-1:0] fall_en_i;
    logic             int_fin_i;
    logic [WIDTH-1:0] state_o;
    logic [WIDTH-1:0] pending_o;
    logic [WIDTH-1:0] cause_o;
    logic             int_req_o;
    modport master (
        output in_i, rise_en_i, fall_en_i, int_fin_i,
        input  state_o, pending_o, cause_o, int_req_o
    );
    modport slave (
        input  in_i, rise_en_i, fall_en_i, int_fin_i,
        output state_o, pending_o, cause_o, int_req_o
    );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: synchronised, debounced GPIO inputs raising sticky edge events into a request/finish interrupt handshake
module gpio_irq_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic       clk_i,
    input logic       rst_n_i,
    gpio_irq_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef enum logic {IDLE, REQ} fsm_t;
    fsm_t                      fsm_q, fsm_d;
    logic [WIDTH-1:0]          sync1_q, sync2_q;
    logic [WIDTH-1:0]          level_q, level_d;
    logic [WIDTH-1:0]          pending_q, pending_d;
    logic [WIDTH-1:0]          cause_q, cause_d;
    logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]          evt;
    logic                      fin;
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
                    level_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end
    assign evt = (level_d & ~level_q & bus.rise_en_i) | (~level_d & level_q & bus.fall_en_i);
    assign fin = (fsm_q == REQ) && bus.int_fin_i;
    always_comb begin
        pending_d = (pending_q & ~(fin ? cause_q : '0)) | evt;
        cause_d   = (fsm_q == IDLE && |pending_q) ? pending_q : cause_q;
        fsm_d     = (fsm_q == IDLE) ? (|pending_q ? REQ : IDLE) : (fin ? IDLE : REQ);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            cause_q   <= '0;
            fsm_q     <= IDLE;
        end else begin
            sync1_q   <= bus.in_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
            fsm_q     <= fsm_d;
        end
    end
    assign bus.state_o   = level_q;
    assign bus.pending_o = pending_q;
    assign bus.cause_o   = cause_q;
    assign bus.int_req_o = (fsm_q == REQ);
endmodule
